// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
package adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ADD  = ST_ADD,
        DONE = ST_DONE
    } adder_seq_state_t;

    // Width of the nibble index; never narrower than one bit.
    function automatic int idx_width(input int num_nibbles);
        return (num_nibbles <= 2) ? 1 : $clog2(num_nibbles);
    endfunction

endpackage

// File: rtl/adder_seq_if.sv
// Start/busy/done handshake plus operand and result bus of the sequencer.
interface adder_seq_if #(parameter int NUM_NIBBLES = 4);
    import adder_seq_pkg::*;

    localparam int W = NIBBLE_W * NUM_NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         overflow;

    modport master (
        output start, op_a, op_b, carry_in,
        input  busy, done, sum, overflow
    );

    modport slave (
        input  start, op_a, op_b, carry_in,
        output busy, done, sum, overflow
    );

endinterface

// File: rtl/adder_seq_ctrl_adder_4bit.sv
// Combinational 4-bit adder; overflow is the unsigned carry out.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       overflow
);

    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial wide adder: one adder_4bit reused over NUM_NIBBLES cycles,
// carry chained through a register, LSB nibble first.
// Build option: ADDER_SEQ_SIGNED_OVF_EN selects signed overflow of the
// final nibble instead of the unsigned carry out.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int NUM_NIBBLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    adder_seq_if.slave bus
);

    localparam int W     = NIBBLE_W * NUM_NIBBLES;
    localparam int IDX_W = idx_width(NUM_NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

    adder_seq_state_t state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       nib_s;
    logic             nib_cout;
    logic             nib_ovf;

    // Operands shift right each ADD cycle, so the live nibble is always [3:0].
    adder_4bit u_adder (
        .a        (a_q[3:0]),
        .b        (b_q[3:0]),
        .carry_in (carry_q),
        .sum      (nib_s),
        .overflow (nib_cout)
    );

`ifdef ADDER_SEQ_SIGNED_OVF_EN
    // Carry into bit 3 is recovered from the sum bit, then XORed with carry out.
    assign nib_ovf = (a_q[3] ^ b_q[3] ^ nib_s[3]) ^ nib_cout;
`else
    assign nib_ovf = nib_cout;
`endif

    // Next-state and datapath decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    carry_d = bus.carry_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
                carry_d = nib_cout;
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    ovf_d   = nib_ovf;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == ADD);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl with NUM_NIBBLES = 4.
module tb_adder_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   chk_en;

    adder_seq_if #(.NUM_NIBBLES(N)) bus_if ();

    adder_seq_ctrl #(.NUM_NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Overflow from whole-word arithmetic on plain integers.
    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
`ifdef ADDER_SEQ_SIGNED_OVF_EN
        longint s   = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        longint lim = longint'(1) << (W - 1);
        return (s >= lim) || (s < -lim);
`else
        longint t = longint'(a) + longint'(b) + longint'(c);
        return (t >> W) != 0;
`endif
    endfunction

    // Behavioural model: a countdown of busy cycles and the full-width result.
    int          m_left;
    bit          m_done;
    int          m_k;
    longint      m_res;
    logic        m_ovf_pend;
    logic [W-1:0] m_sum;
    logic        m_ovf;

    initial begin
        m_left = 0; m_done = 0; m_k = 0; m_res = 0;
        m_ovf_pend = 0; m_sum = '0; m_ovf = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_k = 0; m_sum = '0; m_ovf = 0;
        end else if (m_left > 0) begin
            m_k++;
            m_sum = W'(m_res % (longint'(1) << (4 * m_k)));
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_ovf  = m_ovf_pend;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (bus_if.start) begin
            m_res      = longint'(bus_if.op_a) + longint'(bus_if.op_b) + longint'(bus_if.carry_in);
            m_ovf_pend = model_ovf(bus_if.op_a, bus_if.op_b, bus_if.carry_in);
            m_left     = N;
            m_k        = 0;
            m_sum      = '0;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     W'(bus_if.busy),     W'(m_left > 0));
            chk("done",     W'(bus_if.done),     W'(m_done));
            chk("sum",      bus_if.sum,          m_sum);
            chk("overflow", W'(bus_if.overflow), W'(m_ovf));
        end
    end

    // Wait for the done cycle; returns the number of busy cycles seen.
    task automatic wait_done(output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                ok = 1;
                break;
            end
            if (bus_if.busy) busy_cycles++;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL done_timeout no done pulse within 20 cycles at %0t", $time);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] exp_sum, input logic exp_ovf,
                          output int busy_cycles);
        bit ok;
        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.op_a     = a;
        bus_if.op_b     = b;
        bus_if.carry_in = c;
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.op_a     = W'($urandom);
        bus_if.op_b     = W'($urandom);
        bus_if.carry_in = 1'($urandom);
        if (bus_if.busy) busy_cycles = 1; else busy_cycles = 0;
        begin
            int more;
            wait_done(more, ok);
            busy_cycles += more;
        end
        if (ok) begin
            chk({name, "_sum"}, bus_if.sum, exp_sum);
            chk({name, "_ovf"}, W'(bus_if.overflow), W'(exp_ovf));
        end
    endtask

    initial begin
        int  bc;
        bit  ok;
        logic exp_ovf;
        checks = 0;
        errors = 0;
        chk_en = 0;
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op_a = '0;
        bus_if.op_b = '0;
        bus_if.carry_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_busy", W'(bus_if.busy), '0);
        chk("reset_done", W'(bus_if.done), '0);
        chk("reset_sum",  bus_if.sum, '0);
        chk("reset_ovf",  W'(bus_if.overflow), '0);
        rst = 1'b0;

        run_op("t1", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, bc);
        chk("t1_busy_cycles", W'(bc), W'(4));
        run_op("t2", 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, bc);
`ifdef ADDER_SEQ_SIGNED_OVF_EN
        exp_ovf = 1'b0;
`else
        exp_ovf = 1'b1;
`endif
        run_op("t3", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, exp_ovf, bc);
        run_op("t4", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, ~exp_ovf, bc);

        // start held high through ADD and DONE
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op_a = 16'h0001;
        bus_if.op_b = 16'h0001;
        bus_if.carry_in = 1'b0;
        @(negedge clk);
        bus_if.op_a = 16'hAAAA;
        bus_if.op_b = 16'h1111;
        wait_done(bc, ok);
        if (ok) chk("t5_first_sum", bus_if.sum, 16'h0002);
        @(negedge clk);
        chk("t5_idle_gap_busy", W'(bus_if.busy), '0);
        @(negedge clk);
        chk("t5_second_accept", W'(bus_if.busy), W'(1));
        bus_if.start = 1'b0;
        wait_done(bc, ok);
        if (ok) chk("t5_second_sum", bus_if.sum, 16'hBBBB);

        // reset on the second ADD edge
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op_a = 16'hFFFF;
        bus_if.op_b = 16'hFFFF;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_busy", W'(bus_if.busy), '0);
        chk("t6_rst_done", W'(bus_if.done), '0);
        chk("t6_rst_sum",  bus_if.sum, '0);
        chk("t6_rst_ovf",  W'(bus_if.overflow), '0);
        repeat (6) begin
            @(negedge clk);
            chk("t6_no_done", W'(bus_if.done), '0);
        end
        run_op("t6_after", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, bc);

        // randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus_if.start    = ($urandom_range(0, 2) == 0);
            bus_if.op_a     = W'($urandom);
            bus_if.op_b     = W'($urandom);
            bus_if.carry_in = 1'($urandom);
            rst             = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_if.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
